// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   A hex value is captured into a shadow register on `load` and committed to
//   the displayed (active) register only at frame boundaries, so a frame never
//   shows a mix of old and new digits. Each digit gets a PRESCALE-cycle slot
//   whose first DEADTIME cycles keep every anode off to avoid ghosting.
//
// Parameters
//   DIGITS   number of digits (2..16)
//   PRESCALE clock cycles per digit slot (>= 2)
//   DEADTIME dark cycles at the start of each slot (< PRESCALE)
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   value  in   hex nibbles, nibble i = value[4*i+3:4*i] is digit i (digit 0 leftmost)
//   dp_in  in   decimal point per digit, 1 = lit
//   load   in   one-cycle strobe capturing value/dp_in into the shadow register
//   blank  in   live per-digit blank mask, 1 = digit dark (not shadowed)
//   anode  out  active-low digit enables, digit i drives anode[DIGITS-1-i]
//   seg    out  active-low segments {g,f,e,d,c,b,a}
//   dp     out  active-low decimal point
//   frame  out  one-cycle pulse registered from the commit boundary
//
// Build option
//   SEG7_LEADING_ZERO_BLANK_EN: when defined, leading zero digits of the active
//   value are suppressed (the last digit always shows; a suppressed digit's
//   decimal point still lights if set).
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int DEADTIME = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame
);

  localparam int CW = ($clog2(PRESCALE) > 0) ? $clog2(PRESCALE) : 1;
  localparam int IW = ($clog2(DIGITS) > 0) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] DEAD_END = CW'(DEADTIME);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic                  pending_q, pending_d;
  logic [4*DIGITS-1:0]   active_val_q, active_val_d;
  logic [DIGITS-1:0]     active_dp_q, active_dp_d;
  logic [DIGITS-1:0]     anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  logic                  boundary;
  logic                  in_dead;
  logic [3:0]            sel_nib;
  logic                  sel_dp;
  logic                  sel_blank;
  logic                  sel_suppress;
  logic [DIGITS-1:0]     sel_onehot;

  // Slot counter and digit index; both wrap explicitly.
  always_comb begin
    boundary = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // Shadow/commit. A load on the boundary cycle bypasses the shadow so the
  // next frame already shows it and nothing is left pending.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
    end
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        active_val_d = value;
        active_dp_d  = dp_in;
      end else if (pending_q) begin
        active_val_d = shadow_val_q;
        active_dp_d  = shadow_dp_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Select the current digit's data without variable-width indexing.
  always_comb begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic zero_run;
    zero_run = 1'b1;
`endif
    sel_nib      = '0;
    sel_dp       = 1'b0;
    sel_blank    = 1'b0;
    sel_suppress = 1'b0;
    sel_onehot   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      zero_run = zero_run && (active_val_q[4*i +: 4] == 4'h0);
`endif
      if (idx_q == IW'(i)) begin
        sel_nib                = active_val_q[4*i +: 4];
        sel_dp                 = active_dp_q[i];
        sel_blank              = blank[i];
        sel_onehot[DIGITS-1-i] = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        sel_suppress           = zero_run && (i != DIGITS - 1);
`endif
      end
    end
  end

  always_comb begin
    in_dead = (cnt_q < DEAD_END);
    anode_d = '1;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    frame_d = boundary;
    if (!in_dead && !sel_blank) begin
      if (sel_suppress) begin
        // Suppressed digit keeps only its decimal point, if set.
        if (sel_dp) begin
          anode_d = ~sel_onehot;
          dp_d    = 1'b0;
        end
      end else begin
        anode_d = ~sel_onehot;
        seg_d   = decode(sel_nib);
        dp_d    = ~sel_dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      anode_q      <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_q      <= frame_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, PRESCALE=4, DEADTIME=1.
// One frame is 16 cycles. A slot table gives the anode pattern, the digit
// shown and the frame flag for each of the 16 output cycles of a frame.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  blank;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS  (4),
    .PRESCALE(4),
    .DEADTIME(1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .value(value),
    .dp_in(dp_in),
    .load (load),
    .blank(blank),
    .anode(anode),
    .seg  (seg),
    .dp   (dp),
    .frame(frame)
  );

  typedef struct {
    logic [3:0] anode;
    logic       frame;
    int         digit;   // -1 = dead-time cycle
  } slot_t;

  slot_t      tbl [16];
  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks   = 0;
  int failures = 0;
  int k        = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es,
                       input logic ed, input logic ef);
    checks++;
    if (anode !== ea || seg !== es || dp !== ed || frame !== ef) begin
      failures++;
      $display("FAIL %s k=%0d: got anode=%b seg=%h dp=%b frame=%b, expected anode=%b seg=%h dp=%b frame=%b",
               name, k, anode, seg, dp, frame, ea, es, ed, ef);
    end
  endtask

  task automatic expect_slot(input int p, input logic [15:0] v, input logic [3:0] dpv,
                             input logic [3:0] blk, output logic [3:0] ea,
                             output logic [6:0] es, output logic ed, output logic ef);
    int   d;
    logic sup;
    ef  = tbl[p].frame;
    ea  = 4'b1111;
    es  = 7'h7F;
    ed  = 1'b1;
    d   = tbl[p].digit;
    sup = 1'b0;
    if (d >= 0 && !blk[d]) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      sup = (d != 3);
      for (int j = 0; j <= d; j++) if (v[4*j +: 4] != 4'h0) sup = 1'b0;
`endif
      if (sup) begin
        if (dpv[d]) begin
          ea = tbl[p].anode;
          ed = 1'b0;
        end
      end else begin
        ea = tbl[p].anode;
        es = segtab[v[4*d +: 4]];
        ed = ~dpv[d];
      end
    end
  endtask

  // Runs one aligned frame expecting active value v / dp dpv, with up to two
  // loads injected before the edge of the given phases.
  task automatic run_frame(input string name, input logic [15:0] v, input logic [3:0] dpv,
                           input int lp0, input logic [15:0] lv0, input logic [3:0] ld0,
                           input int lp1, input logic [15:0] lv1, input logic [3:0] ld1);
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed, ef;
    for (int p = 0; p < 16; p++) begin
      if (p == lp0) begin
        load = 1'b1; value = lv0; dp_in = ld0;
      end else if (p == lp1) begin
        load = 1'b1; value = lv1; dp_in = ld1;
      end
      tick();
      load = 1'b0;
      expect_slot(p, v, dpv, blank, ea, es, ed, ef);
      check(name, ea, es, ed, ef);
    end
  endtask

  initial begin
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed, ef;

    tbl[0]  = '{4'b1111, 1'b0, -1};
    tbl[1]  = '{4'b0111, 1'b0, 0};
    tbl[2]  = '{4'b0111, 1'b0, 0};
    tbl[3]  = '{4'b0111, 1'b0, 0};
    tbl[4]  = '{4'b1111, 1'b0, -1};
    tbl[5]  = '{4'b1011, 1'b0, 1};
    tbl[6]  = '{4'b1011, 1'b0, 1};
    tbl[7]  = '{4'b1011, 1'b0, 1};
    tbl[8]  = '{4'b1111, 1'b0, -1};
    tbl[9]  = '{4'b1101, 1'b0, 2};
    tbl[10] = '{4'b1101, 1'b0, 2};
    tbl[11] = '{4'b1101, 1'b0, 2};
    tbl[12] = '{4'b1111, 1'b0, -1};
    tbl[13] = '{4'b1110, 1'b0, 3};
    tbl[14] = '{4'b1110, 1'b0, 3};
    tbl[15] = '{4'b1110, 1'b1, 3};

    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank = '0;
    repeat (3) begin
      tick();
      check("reset", 4'b1111, 7'h7F, 1'b1, 1'b0);
    end
    rst = 1'b0;
    k   = 0;

    // Plain scan of value 0
    run_frame("scan_f0", 16'h0000, 4'b0000, -1, '0, '0, -1, '0, '0);
    run_frame("scan_f1", 16'h0000, 4'b0000, -1, '0, '0, -1, '0, '0);

    // Mid-frame load is deferred to the next frame
    run_frame("defer_pre",  16'h0000, 4'b0000, 5, 16'h12AF, 4'b0000, -1, '0, '0);
    // Boundary load goes straight to the next frame
    run_frame("defer_post", 16'h12AF, 4'b0000, 15, 16'h8888, 4'b0000, -1, '0, '0);
    // Two loads in one frame: the later one wins
    run_frame("bound_load", 16'h8888, 4'b0000, 3, 16'h1111, 4'b0000, 7, 16'h3C5E, 4'b0000);
    run_frame("last_wins",  16'h3C5E, 4'b0000, -1, '0, '0, -1, '0, '0);

    // Live blank mask plus decimal point
    blank = 4'b0100;
    run_frame("blank_pre", 16'h3C5E, 4'b0000, 8, 16'h9876, 4'b0001, -1, '0, '0);
    run_frame("blank_dp",  16'h9876, 4'b0001, -1, '0, '0, -1, '0, '0);
    blank = 4'b0000;

    // Reset in the digit-2 slot
    for (int p = 0; p < 10; p++) begin
      tick();
      expect_slot(p, 16'h9876, 4'b0001, blank, ea, es, ed, ef);
      check("pre_rst", ea, es, ed, ef);
    end
    rst = 1'b1;
    tick();
    check("mid_reset", 4'b1111, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;
    k   = 0;
    run_frame("after_rst", 16'h0000, 4'b0000, -1, '0, '0, -1, '0, '0);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    run_frame("lzb_load", 16'h0000, 4'b0000, 4, 16'h0050, 4'b0000, -1, '0, '0);
    run_frame("lzb_0050", 16'h0050, 4'b0000, 10, 16'h0000, 4'b0000, -1, '0, '0);
    run_frame("lzb_0000", 16'h0000, 4'b0000, 10, 16'h0000, 4'b0001, -1, '0, '0);
    run_frame("lzb_dp",   16'h0000, 4'b0001, -1, '0, '0, -1, '0, '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
